pc_fetch_stage: RTL

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage_pkg.sv | 19 +
 rtl/pc_fetch_stage_pc_reg.sv | 39 +++
 rtl/pc_fetch_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN             : datapath / address width
//   DEFAULT_RESET_PC : default PC loaded on reset
//   DEFAULT_PC_STEP  : default sequential PC increment
//   fetch_state_e    : fetch FSM state encoding
package pc_fetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,   // request presented to instruction memory
      ST_WAIT = 2'd1,   // request accepted, waiting for the response
      ST_HOLD = 2'd2    // instruction buffered, waiting for decode
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_stage_pc_reg.sv
// pc_reg: loadable XLEN-bit register holding the program counter.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, loads RESET_VAL
//   load  : when high, d is captured on the next rising edge
//   d     : value to load
//   q     : current register value
module pc_reg
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   logic [XLEN-1:0] val_q, val_d;

   always_comb begin
      val_d = val_q;
      if (load) begin
         val_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_q <= RESET_VAL;
      end else begin
         val_q <= val_d;
      end
   end

   assign q = val_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: single-outstanding instruction fetch stage.
// Issues one instruction-memory request at a time from pc, buffers the
// returned word for decode and advances pc. A redirect replaces pc with
// next_pc_in and squashes any fetch already in flight.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   next_pc_in, redirect   : redirect target and one-cycle redirect strobe
//   pc_plus_step           : pc + PC_STEP (combinational)
//   imem_req_valid/ready   : fetch request handshake, imem_addr is the address
//   imem_rsp_valid/data    : returned instruction word
//   if_valid/ready         : handshake to decode, if_instr/if_pc carry the word
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] next_pc_in,
   input  logic            redirect,
   output logic [XLEN-1:0] pc_plus_step,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_load;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic            drop_q, drop_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;

   pc_reg #(
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pc_load),
      .d     (pc_d),
      .q     (pc_q)
   );

   assign pc_plus_step = pc_q + PC_STEP;

   // Gated by rst_n so no request is shown while reset is being applied.
   assign imem_req_valid = rst_n && (state_q == ST_REQ);
   assign imem_addr      = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = if_instr_q;
   assign if_pc          = if_pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pc_load       = 1'b0;
      inflight_pc_d = inflight_pc_q;
      drop_d        = drop_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;

      unique case (state_q)
         ST_REQ: begin
            if (redirect) begin
               pc_load = 1'b1;
               pc_d    = next_pc_in;
               // A request accepted alongside a redirect still gets a
               // response; wait for it and throw it away so only one
               // request is ever outstanding.
               if (imem_req_ready) begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (imem_req_ready) begin
               inflight_pc_d = pc_q;
               state_d       = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect) begin
               pc_load = 1'b1;
               pc_d    = next_pc_in;
            end
            if (imem_rsp_valid) begin
               if (drop_q || redirect) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  if_valid_d = 1'b1;
                  if_instr_d = imem_rsp_data;
                  if_pc_d    = inflight_pc_q;
                  pc_load    = 1'b1;
                  pc_d       = pc_plus_step;
                  state_d    = ST_HOLD;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pc_load    = 1'b1;
               pc_d       = next_pc_in;
               if_valid_d = 1'b0;
               state_d    = ST_REQ;
            end else if (if_ready) begin
               if_valid_d = 1'b0;
               state_d    = ST_REQ;
            end
         end

         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_REQ;
         inflight_pc_q <= '0;
         drop_q        <= 1'b0;
         if_valid_q    <= 1'b0;
         if_instr_q    <= '0;
         if_pc_q       <= '0;
      end else begin
         state_q       <= state_d;
         inflight_pc_q <= inflight_pc_d;
         drop_q        <= drop_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
      end
   end

endmodule
